// File: rtl/serial_link_pkg.sv
// Shared link constants and the transmitter state type, also used by the detector side.
package serial_link_pkg;

  localparam logic [3:0]  PREAMBLE         = 4'b0111;
  localparam int unsigned PREAMBLE_LEN     = 4;
  localparam logic        IDLE_BIT         = 1'b0;
  localparam int unsigned STUFF_AFTER_ONES = 2;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    STUFF,
    PAR
  } tx_state_t;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Word-in / bit-out bus of the serial frame transmitter.
interface serial_frame_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_bit;
  logic                  out_valid;
  logic                  tx_done;

  // Word source, also observing the serial side.
  modport master (
    output in_data, in_valid,
    input  in_ready, out_bit, out_valid, tx_done
  );

  // The transmitter itself.
  modport slave (
    input  in_data, in_valid,
    output in_ready, out_bit, out_valid, tx_done
  );

endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble 0111, MSB-first payload, optional even parity,
// with payload/parity bit-stuffed so 111 never appears outside the preamble.
module serial_frame_tx
  import serial_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          PARITY_EN  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  serial_frame_tx_if.slave  bus
);

  localparam int unsigned CNT_W     = $clog2(DATA_WIDTH + 1);
  localparam int unsigned IDX_W     = $clog2(PREAMBLE_LEN);
  localparam logic [1:0]  STUFF_CNT = 2'(STUFF_AFTER_ONES);

  // State describes the bit currently on the line; outputs are registered with it.
  tx_state_t             state_q;
  tx_state_t             ret_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  parity_q;
  logic [1:0]            ones_q;
  logic                  in_ready_q;
  logic                  out_bit_q;
  logic                  out_valid_q;
  logic                  tx_done_q;

  tx_state_t             nxt_c;
  tx_state_t             follow_c;
  logic                  data_bit_c;
  logic [1:0]            data_ones_c;
  logic [1:0]            par_ones_c;
  logic                  data_last_c;
  logic                  par_last_c;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.tx_done   = tx_done_q;

  // Next line state and the run/last-bit bookkeeping for the candidate next bit.
  always_comb begin
    data_bit_c  = shift_q[DATA_WIDTH-1];
    data_ones_c = data_bit_c ? ones_q + 2'd1 : 2'd0;
    par_ones_c  = parity_q ? ones_q + 2'd1 : 2'd0;
    data_last_c = (cnt_q == CNT_W'(DATA_WIDTH - 1)) && !PARITY_EN
                  && (data_ones_c != STUFF_CNT);
    par_last_c  = (par_ones_c != STUFF_CNT);

    // Where the frame continues after the current payload/parity bit, ignoring stuffing.
    follow_c = IDLE;
    if (state_q == DATA && cnt_q != CNT_W'(DATA_WIDTH)) begin
      follow_c = DATA;
    end else if (state_q == DATA && PARITY_EN) begin
      follow_c = PAR;
    end

    nxt_c = state_q;
    case (state_q)
      IDLE:      if (bus.in_valid && in_ready_q) nxt_c = PRE;
      PRE:       if (idx_q == '0) nxt_c = DATA;
      DATA, PAR: nxt_c = (ones_q == STUFF_CNT) ? STUFF : follow_c;
      STUFF:     nxt_c = ret_q;
      default:   nxt_c = IDLE;
    endcase
  end

  // Frame sequencer: registers the state together with the bit it puts on the line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      idx_q       <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      parity_q    <= 1'b0;
      ones_q      <= '0;
      in_ready_q  <= 1'b0;
      out_bit_q   <= IDLE_BIT;
      out_valid_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q   <= nxt_c;
      tx_done_q <= 1'b0;
      case (nxt_c)
        PRE: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b1;
          if (state_q == IDLE) begin
            shift_q   <= bus.in_data;
            parity_q  <= ^bus.in_data;
            cnt_q     <= '0;
            ones_q    <= '0;
            idx_q     <= IDX_W'(PREAMBLE_LEN - 1);
            out_bit_q <= PREAMBLE[PREAMBLE_LEN-1];
          end else begin
            idx_q     <= idx_q - IDX_W'(1);
            out_bit_q <= PREAMBLE[idx_q - IDX_W'(1)];
          end
        end
        DATA: begin
          out_valid_q <= 1'b1;
          out_bit_q   <= data_bit_c;
          shift_q     <= shift_q << 1;
          cnt_q       <= cnt_q + CNT_W'(1);
          ones_q      <= data_ones_c;
          tx_done_q   <= data_last_c;
        end
        PAR: begin
          out_valid_q <= 1'b1;
          out_bit_q   <= parity_q;
          ones_q      <= par_ones_c;
          tx_done_q   <= par_last_c;
        end
        STUFF: begin
          out_valid_q <= 1'b1;
          out_bit_q   <= 1'b0;
          ones_q      <= '0;
          ret_q       <= follow_c;
          tx_done_q   <= (follow_c == IDLE);
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_bit_q   <= IDLE_BIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: one instance with parity, one without, checked against a frame model.
module tb_serial_frame_tx;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  bit   exp_q[$];

  serial_frame_tx_if #(.DATA_WIDTH(8)) ifa ();
  serial_frame_tx_if #(.DATA_WIDTH(8)) ifb ();

  serial_frame_tx #(.DATA_WIDTH(8), .PARITY_EN(1'b1)) u_par (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  serial_frame_tx #(.DATA_WIDTH(8), .PARITY_EN(1'b0)) u_nopar (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Frame model: preamble, raw payload (+parity), then insert a 0 after every second consecutive 1.
  function automatic void build_frame(input logic [7:0] d, input bit pe);
    bit raw[$];
    int run;
    exp_q.delete();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    for (int i = 7; i >= 0; i--) raw.push_back(d[i]);
    if (pe) raw.push_back(^d);
    run = 0;
    foreach (raw[i]) begin
      exp_q.push_back(raw[i]);
      run = raw[i] ? run + 1 : 0;
      if (run == 2) begin
        exp_q.push_back(1'b0);
        run = 0;
      end
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.in_valid = 1'b0; ifb.in_data = '0;
    #2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_checks++;
      if ({ifa.in_ready, ifa.out_valid, ifa.out_bit, ifa.tx_done,
           ifb.in_ready, ifb.out_valid, ifb.out_bit, ifb.tx_done} !== 8'h00)
        $display("FAIL reset_hold: got rdy/vld/bit/done a=%b%b%b%b b=%b%b%b%b, required all 0",
                 ifa.in_ready, ifa.out_valid, ifa.out_bit, ifa.tx_done,
                 ifb.in_ready, ifb.out_valid, ifb.out_bit, ifb.tx_done);
      if ({ifa.in_ready, ifa.out_valid, ifa.out_bit, ifa.tx_done,
           ifb.in_ready, ifb.out_valid, ifb.out_bit, ifb.tx_done} !== 8'h00) n_fail++;
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got a=%b b=%b, required 1", ifa.in_ready, ifb.in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if (ifa.out_valid !== 1'b0 || ifa.out_bit !== 1'b0 || ifb.out_valid !== 1'b0 || ifb.out_bit !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_line: got a vld/bit=%b%b b vld/bit=%b%b, required 00",
                 ifa.out_valid, ifa.out_bit, ifb.out_valid, ifb.out_bit);
      end
    end
  endtask

  // Sends one word to instance sel (0 = parity, 1 = no parity) and checks the whole frame.
  task automatic run_frame(input int sel, input logic [7:0] d, input int exp_len, input string nm);
    logic ob, ov, td, rdy;
    int   got_len, done_cnt, done_pos;
    build_frame(d, sel == 0);
    @(negedge clock);
    if (sel == 0) begin ifa.in_data = d; ifa.in_valid = 1'b1; rdy = ifa.in_ready; end
    else          begin ifb.in_data = d; ifb.in_valid = 1'b1; rdy = ifb.in_ready; end
    n_checks++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before_accept: got %b, required 1", nm, rdy);
    end
    @(posedge clock); #1;
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    ifa.in_data = 8'($urandom); ifb.in_data = 8'($urandom);
    got_len = 0; done_cnt = 0; done_pos = -1;
    for (int c = 0; c < 40; c++) begin
      ob = (sel == 0) ? ifa.out_bit   : ifb.out_bit;
      ov = (sel == 0) ? ifa.out_valid : ifb.out_valid;
      td = (sel == 0) ? ifa.tx_done   : ifb.tx_done;
      if (ov !== 1'b1) break;
      if (got_len < exp_q.size()) begin
        n_checks++;
        if (ob !== exp_q[got_len]) begin
          n_fail++;
          $display("FAIL %s bit%0d: got %b, required %b", nm, got_len, ob, exp_q[got_len]);
        end
      end
      if (td === 1'b1) begin done_cnt++; done_pos = got_len; end
      got_len++;
      @(posedge clock); #1;
    end
    n_checks++;
    if (got_len != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s length: got %0d, required %0d", nm, got_len, exp_q.size());
    end
    if (exp_len != 0) begin
      n_checks++;
      if (got_len != exp_len) begin
        n_fail++;
        $display("FAIL %s length_const: got %0d, required %0d", nm, got_len, exp_len);
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_pos != exp_q.size() - 1) begin
      n_fail++;
      $display("FAIL %s tx_done: got %0d pulses last at %0d, required 1 at %0d",
               nm, done_cnt, done_pos, exp_q.size() - 1);
    end
    ob = (sel == 0) ? ifa.out_bit : ifb.out_bit;
    td = (sel == 0) ? ifa.tx_done : ifb.tx_done;
    n_checks++;
    if (ob !== 1'b0 || td !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after: got bit=%b done=%b, required 0 0", nm, ob, td);
    end
  endtask

  task automatic test_directed();
    run_frame(0, 8'hA5, 13, "a5_par");
    run_frame(0, 8'hFF, 17, "ff_par");
    run_frame(1, 8'h03, 13, "03_nopar");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_frame(0, 8'($urandom), 0, "rand_par");
      run_frame(1, 8'($urandom), 0, "rand_nopar");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3];
    bit   exp_b[$];
    bit   exp_v[$];
    bit   got_b[$];
    bit   got_v[$];
    logic [3:0] sr;
    int   k, det;
    bit   acc, started, ended;
    w[0] = 8'hFF; w[1] = 8'h7E; w[2] = 8'h00;
    for (int f = 0; f < 3; f++) begin
      build_frame(w[f], 1'b1);
      foreach (exp_q[i]) begin exp_b.push_back(exp_q[i]); exp_v.push_back(1'b1); end
      if (f < 2) begin exp_b.push_back(1'b0); exp_v.push_back(1'b0); end
    end
    k = 0; det = 0; sr = '0; started = 1'b0; ended = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (k < 3) begin ifa.in_valid = 1'b1; ifa.in_data = w[k]; end
      else       begin ifa.in_valid = 1'b0; ifa.in_data = '0; end
      acc = (k < 3) && (ifa.in_ready === 1'b1);
      @(posedge clock);
      if (acc) k++;
      #1;
      sr = {sr[2:0], ifa.out_bit};
      if (sr == 4'b0111) det++;
      if (ifa.out_valid === 1'b1) started = 1'b1;
      if (started) begin
        if (k == 3 && ifa.out_valid !== 1'b1) begin ended = 1'b1; break; end
        got_b.push_back(ifa.out_bit);
        got_v.push_back(ifa.out_valid);
      end
    end
    ifa.in_valid = 1'b0;
    n_checks++;
    if (!ended || got_b.size() != exp_b.size()) begin
      n_fail++;
      $display("FAIL b2b_length: got %0d bits (ended=%0d), required %0d", got_b.size(), ended, exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      n_checks++;
      if (got_b[i] !== exp_b[i] || got_v[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL b2b_pos%0d: got bit/vld %b%b, required %b%b", i, got_b[i], got_v[i], exp_b[i], exp_v[i]);
      end
    end
    n_checks++;
    if (det != 3) begin
      n_fail++;
      $display("FAIL b2b_detector: got %0d preamble hits, required 3", det);
    end
  endtask

  task automatic test_reset_mid_frame();
    build_frame(8'hFF, 1'b1);
    @(negedge clock);
    ifa.in_data = 8'hFF; ifa.in_valid = 1'b1;
    @(posedge clock); #1;
    ifa.in_valid = 1'b0;
    // Emission index 11 is the sixth payload bit of 0xFF (two stuff bits precede it).
    repeat (11) begin @(posedge clock); #1; end
    n_checks++;
    if (ifa.out_valid !== 1'b1 || ifa.out_bit !== exp_q[11]) begin
      n_fail++;
      $display("FAIL midreset_pre: got vld/bit %b%b, required 1%b", ifa.out_valid, ifa.out_bit, exp_q[11]);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (ifa.out_valid !== 1'b0 || ifa.out_bit !== 1'b0 || ifa.in_ready !== 1'b0 || ifa.tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: got vld/bit/rdy/done %b%b%b%b, required 0000",
               ifa.out_valid, ifa.out_bit, ifa.in_ready, ifa.tx_done);
    end
    @(posedge clock); #1;
    n_checks++;
    if (ifa.tx_done !== 1'b0 || ifa.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_hold: got done/vld %b%b, required 00", ifa.tx_done, ifa.out_valid);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (ifa.in_ready !== 1'b1 || ifa.tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release: got rdy/done %b%b, required 10", ifa.in_ready, ifa.tx_done);
    end
    run_frame(0, 8'hA5, 13, "after_reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
